// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter, active-low req_/grnt_, registered outputs.
// Define ARB_QUANTUM_EN to enable hold-quantum preemption (QUANTUM, CNT_W).
module bus_arbiter #(
   parameter int QUANTUM = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_,
   output logic [3:0] grnt_,
   output logic [1:0] owner,
   output logic       bus_busy,
   output logic       preempt
);

   localparam logic IDLE  = 1'b0;
   localparam logic OWNED = 1'b1;

   logic       state;
   logic       state_nxt;
   logic [1:0] owner_nxt;
   logic [3:0] grnt_nxt;
   logic [2:0] pick_all;
   logic [2:0] pick_oth;

   // Round-robin pick starting after base; base itself is the last candidate.
   // Result is {found, index}.
   function automatic logic [2:0] rr_pick(
      input logic [3:0] rq,
      input logic [1:0] base,
      input logic       incl
   );
      logic [2:0] res;
      logic [1:0] c;
      res = 3'b000;
      if (incl && !rq[base])
         res = {1'b1, base};
      for (int k = 3; k >= 1; k--) begin
         c = base + 2'(k);
         if (!rq[c])
            res = {1'b1, c};
      end
      return res;
   endfunction

   assign pick_all = rr_pick(req_, owner, 1'b1);
   assign pick_oth = rr_pick(req_, owner, 1'b0);

`ifdef ARB_QUANTUM_EN
   logic [CNT_W-1:0] hold;
   logic [CNT_W-1:0] hold_nxt;
   logic             preempt_nxt;
   logic             at_quantum;

   assign at_quantum = (hold == CNT_W'(QUANTUM - 1));
`else
   logic unused_cfg;

   assign unused_cfg = (QUANTUM > CNT_W);
   assign preempt    = 1'b0;
`endif

   // Next grant decision: idle pickup, release handover, quantum preemption.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
`ifdef ARB_QUANTUM_EN
      hold_nxt    = hold;
      preempt_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (pick_all[2]) begin
               state_nxt = OWNED;
               owner_nxt = pick_all[1:0];
`ifdef ARB_QUANTUM_EN
               hold_nxt  = '0;
`endif
            end
         end
         default: begin
            if (req_[owner]) begin
`ifdef ARB_QUANTUM_EN
               hold_nxt = '0;
`endif
               if (pick_oth[2])
                  owner_nxt = pick_oth[1:0];
               else
                  state_nxt = IDLE;
            end else begin
`ifdef ARB_QUANTUM_EN
               if (at_quantum && pick_oth[2]) begin
                  owner_nxt   = pick_oth[1:0];
                  hold_nxt    = '0;
                  preempt_nxt = 1'b1;
               end else if (!at_quantum) begin
                  hold_nxt = hold + CNT_W'(1);
               end
`endif
            end
         end
      endcase
      grnt_nxt = (state_nxt == OWNED) ? ~(4'b0001 << owner_nxt) : 4'b1111;
   end

   // Registered grant, owner and busy flag; reset drops all grants at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= 2'd0;
         grnt_    <= 4'b1111;
         bus_busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         grnt_    <= grnt_nxt;
         bus_busy <= ~&grnt_nxt;
      end
   end

`ifdef ARB_QUANTUM_EN
   // Hold counter and one-cycle preempt pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold    <= '0;
         preempt <= 1'b0;
      end else begin
         hold    <= hold_nxt;
         preempt <= preempt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed steps plus randomized traffic
// checked against a round-robin reference model.
module tb_bus_arbiter;

   localparam int Q = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_;
   logic [3:0] grnt_;
   logic [1:0] owner;
   logic       bus_busy;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   int m_owner;
   bit m_busy;
   int m_hold;
   bit m_pre;

   bus_arbiter #(.QUANTUM(Q), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_     (req_),
      .grnt_    (grnt_),
      .owner    (owner),
      .bus_busy (bus_busy),
      .preempt  (preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      checks++;
      assert ($countones(~grnt_) <= 1) else begin
         errors++;
         $error("FAIL onehot observed=%b expected=at most one low", grnt_);
      end
   end

   function automatic int pick(input logic [3:0] r, input int base,
                               input bit incl);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (base + k) % 4;
         if (k == 4 && !incl)
            return -1;
         if (!r[c])
            return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = 0;
      m_busy  = 0;
      m_hold  = 0;
      m_pre   = 0;
   endtask

   task automatic model_update(input logic [3:0] r);
      int w;
      m_pre = 0;
      if (!m_busy) begin
         w = pick(r, m_owner, 1);
         if (w >= 0) begin
            m_owner = w;
            m_busy  = 1;
            m_hold  = 0;
         end
      end else if (r[m_owner]) begin
         w = pick(r, m_owner, 0);
         m_hold = 0;
         if (w >= 0)
            m_owner = w;
         else
            m_busy = 0;
      end else begin
         w = pick(r, m_owner, 0);
`ifdef ARB_QUANTUM_EN
         if (m_hold == Q - 1 && w >= 0) begin
            m_owner = w;
            m_hold  = 0;
            m_pre   = 1;
         end else if (m_hold < Q - 1) begin
            m_hold++;
         end
`endif
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      eg = m_busy ? ~(4'b0001 << m_owner) : 4'b1111;
      chk({tag, ".grnt"}, grnt_, eg);
      chk({tag, ".owner"}, {2'b00, owner}, 4'(m_owner));
      chk({tag, ".busy"}, {3'b000, bus_busy}, {3'b000, m_busy});
      chk({tag, ".preempt"}, {3'b000, preempt}, {3'b000, m_pre});
   endtask

   task automatic step(input string tag, input logic [3:0] r);
      @(negedge clk);
      req_ = r;
      @(posedge clk);
      model_update(r);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b0;
      req_ = 4'b1111;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   int         exp_ord[5] = '{1, 2, 3, 0, 1};
   logic [3:0] r;

   initial begin
      rst  = 1'b0;
      req_ = 4'b1111;
      model_reset();

      // reset then idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_grnt", grnt_, 4'b1111);
         chk("rst_owner", {2'b00, owner}, 4'd0);
         chk("rst_busy", {3'b000, bus_busy}, 4'd0);
         chk("rst_preempt", {3'b000, preempt}, 4'd0);
      end
      rst = 1'b1;
      step("idle", 4'b1111);
      chk("idle_grnt", grnt_, 4'b1111);

      // fair rotation, releasing one cycle after each grant
      r = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step("rot", r);
         chk("rot_owner", {2'b00, owner}, 4'(exp_ord[i]));
         chk("rot_busy", {3'b000, bus_busy}, 4'd1);
         r = 4'(1 << exp_ord[i]);
      end

      // master 0 holds while master 2 waits
      step("rel", 4'b1111);
      step("m0", 4'b1110);
      chk("m0_grnt", grnt_, 4'b1110);
      for (int i = 0; i < 100; i++) begin
         step("hold", 4'b1010);
`ifndef ARB_QUANTUM_EN
         chk("hold_grnt", grnt_, 4'b1110);
`endif
      end
      step("hand2", 4'b1011);
      chk("hand2_grnt", grnt_, 4'b1011);

      // asynchronous reset mid-grant
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst_grnt", grnt_, 4'b1111);
      chk("arst_owner", {2'b00, owner}, 4'd0);
      chk("arst_busy", {3'b000, bus_busy}, 4'd0);
      @(negedge clk);
      rst  = 1'b1;
      req_ = 4'b1011;
      @(posedge clk);
      model_update(req_);
      #1;
      check_model("post_rst");
      chk("post_rst_grnt", grnt_, 4'b1011);
      chk("post_rst_owner", {2'b00, owner}, 4'd2);

      // single request and release
      step("rel2", 4'b1111);
      step("single", 4'b1101);
      chk("single_grnt", grnt_, 4'b1101);
      chk("single_owner", {2'b00, owner}, 4'd1);
      step("single_rel", 4'b1111);
      chk("single_rel_grnt", grnt_, 4'b1111);
      chk("single_rel_owner", {2'b00, owner}, 4'd1);

`ifdef ARB_QUANTUM_EN
      // quantum preemption between masters 1 and 3
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step("quant", 4'b0101);
         chk("quant_grnt", grnt_, 4'b1101);
      end
      step("quant_pre", 4'b0101);
      chk("quant_pre_grnt", grnt_, 4'b0111);
      chk("quant_pre_pulse", {3'b000, preempt}, 4'd1);
      step("quant_m3", 4'b0101);
      chk("quant_m3_pulse", {3'b000, preempt}, 4'd0);
      step("quant_m3b", 4'b0101);
      step("quant_back", 4'b1101);
      chk("quant_back_grnt", grnt_, 4'b1101);
`endif

      // randomized traffic, owner tends to keep requesting
      for (int i = 0; i < 500; i++) begin
         r = 4'($urandom);
         if (m_busy && $urandom_range(0, 3) != 0)
            r[m_owner] = 1'b0;
         step("rand", r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
